// File: rtl/conv_engine.sv
// conv_engine: KxK convolution with bias over an RxC map, fed from 1-cycle-latency memories and streamed out on AXI-Stream.
module conv_engine #(
    parameter int INW = 24,
    parameter int R = 9,
    parameter int C = 8,
    parameter int MAXK = 4,
    localparam int K_BITS = $clog2(MAXK + 1),
    localparam int X_ADDR_BITS = $clog2(R * C),
    localparam int W_ADDR_BITS = $clog2(MAXK * MAXK),
    localparam int OUTW = 2 * INW + $clog2(MAXK * MAXK + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          inputs_loaded,
    input  logic        [K_BITS-1:0]      K,
    input  logic signed [INW-1:0]         B,
    output logic        [X_ADDR_BITS-1:0] X_read_addr,
    input  logic signed [INW-1:0]         X_data,
    output logic        [W_ADDR_BITS-1:0] W_read_addr,
    input  logic signed [INW-1:0]         W_data,
    output logic                          compute_finished,
    output logic signed [OUTW-1:0]        AXIS_TDATA,
    output logic                          AXIS_TVALID,
    input  logic                          AXIS_TREADY
);
    localparam int RB = $clog2(R + 1);
    localparam int CB = $clog2(C + 1);
    localparam int NB = $clog2(MAXK * MAXK + 1);
    typedef enum logic [2:0] {IDLE, MAC, OUT, DONE, WAIT} state_t;
    state_t state_q;
    logic [K_BITS-1:0] k_q, i_q, j_q, km1;
    logic signed [INW-1:0] b_q;
    logic [RB-1:0] r_q;
    logic [CB-1:0] c_q;
    logic [NB-1:0] n_q, kk;
    logic signed [OUTW-1:0] acc_q, acc_d, tdata_q, bias_in, bias_q;
    logic signed [2*INW-1:0] prod;
    logic tvalid_q, done_q, k_bad, last_tap, j_wrap, c_wrap, last_out;
    always_comb begin
        prod = (2*INW)'(X_data) * (2*INW)'(W_data);
        acc_d = acc_q + {{(OUTW-2*INW){prod[2*INW-1]}}, prod};
        bias_in = {{(OUTW-INW){B[INW-1]}}, B};
        bias_q = {{(OUTW-INW){b_q[INW-1]}}, b_q};
        kk = NB'(int'(k_q) * int'(k_q));
        km1 = k_q - 1'b1;
        k_bad = int'(K) < 2 || int'(K) > MAXK || int'(K) > R || int'(K) > C;
        j_wrap = j_q == km1;
        last_tap = j_wrap && i_q == km1;
        c_wrap = int'(c_q) == C - int'(k_q);
        last_out = c_wrap && int'(r_q) == R - int'(k_q);
        X_read_addr = X_ADDR_BITS'((int'(r_q) + int'(i_q)) * C + int'(c_q) + int'(j_q));
        W_read_addr = W_ADDR_BITS'(int'(i_q) * int'(k_q) + int'(j_q));
    end
    assign AXIS_TDATA = tdata_q;
    assign AXIS_TVALID = tvalid_q;
    assign compute_finished = done_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q <= '0;
            b_q <= '0;
            r_q <= '0;
            c_q <= '0;
            i_q <= '0;
            j_q <= '0;
            n_q <= '0;
            acc_q <= '0;
            tdata_q <= '0;
            tvalid_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (inputs_loaded) begin
                    k_q <= K;
                    b_q <= B;
                    r_q <= '0;
                    c_q <= '0;
                    i_q <= '0;
                    j_q <= '0;
                    n_q <= '0;
                    acc_q <= bias_in;
                    done_q <= k_bad;
                    state_q <= k_bad ? DONE : MAC;
                end
                MAC: begin
                    n_q <= n_q + 1'b1;
                    if (n_q != '0) acc_q <= acc_d;
                    if (!last_tap) begin
                        j_q <= j_wrap ? '0 : j_q + 1'b1;
                        i_q <= j_wrap ? i_q + 1'b1 : i_q;
                    end
                    if (n_q == kk) begin
                        tdata_q <= acc_d;
                        tvalid_q <= 1'b1;
                        state_q <= OUT;
                    end
                end
                OUT: if (AXIS_TREADY) begin
                    tvalid_q <= 1'b0;
                    if (last_out) begin
                        done_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        c_q <= c_wrap ? '0 : c_q + 1'b1;
                        r_q <= c_wrap ? r_q + 1'b1 : r_q;
                        i_q <= '0;
                        j_q <= '0;
                        n_q <= '0;
                        acc_q <= bias_q;
                        state_q <= MAC;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: if (!inputs_loaded) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: table-driven frames against a reference convolution, plus reset-abort and handshake corner cases.
module tb_conv_engine;
    localparam int INW = 24, R = 9, C = 8, MAXK = 4;
    localparam int K_BITS = 3, XAB = 7, WAB = 4, OUTW = 53;
    logic clk = 1'b0, reset = 1'b1, inputs_loaded = 1'b0, AXIS_TREADY = 1'b0;
    logic [K_BITS-1:0] K = '0;
    logic signed [INW-1:0] B = '0, X_data, W_data;
    logic [XAB-1:0] X_read_addr;
    logic [WAB-1:0] W_read_addr;
    logic compute_finished, AXIS_TVALID;
    logic signed [OUTW-1:0] AXIS_TDATA;
    logic signed [INW-1:0] xmem [R*C];
    logic signed [INW-1:0] wmem [MAXK*MAXK];
    int checks = 0, errors = 0, xviol = 0;
    typedef struct {
        int k; longint b; int xp; int wp; bit rnd; bit drop; int n; longint y0;
    } vec_t;
    vec_t v [9];
    conv_engine #(.INW(INW), .R(R), .C(C), .MAXK(MAXK)) dut (
        .clk(clk), .reset(reset), .inputs_loaded(inputs_loaded), .K(K), .B(B),
        .X_read_addr(X_read_addr), .X_data(X_data), .W_read_addr(W_read_addr), .W_data(W_data),
        .compute_finished(compute_finished), .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID),
        .AXIS_TREADY(AXIS_TREADY)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        X_data <= xmem[X_read_addr];
        W_data <= wmem[W_read_addr];
        if (!reset && int'(X_read_addr) >= R * C) xviol <= xviol + 1;
    end
    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic fill(input int xp, input int wp, input int k);
        for (int a = 0; a < R * C; a++)
            xmem[a] = xp == 0 ? INW'(1) : xp == 1 ? INW'(a) : INW'(-(1 << 23));
        for (int a = 0; a < MAXK * MAXK; a++) wmem[a] = '0;
        for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
                wmem[i*k+j] = wp == 0 ? INW'(1) : wp == 1 ? INW'(i == 1 && j == 1) : INW'(-(1 << 23));
    endtask
    function automatic longint model(input int r, input int c, input int k, input longint b);
        longint s = b;
        for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
                s += longint'(xmem[(r+i)*C+c+j]) * longint'(wmem[i*k+j]);
        return s;
    endfunction
    task automatic collect(input int k, input longint b, input int nexp, input longint y0, input bit rnd, input bit drop);
        int cyc = -1, n = 0, cf = 0, after = -1, hs = 0, r = 0, c = 0;
        bit stall = 0, prev_v = 0;
        logic signed [OUTW-1:0] held = '0;
        while (after < 10 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 2) K = '0;
            if (drop && cyc == 3) inputs_loaded = 1'b0;
            if (compute_finished) cf++;
            if (cf > 0) after++;
            if (stall) begin
                chk("stall_tvalid", AXIS_TVALID, 1);
                chk("stall_tdata", AXIS_TDATA, held);
            end
            if (AXIS_TVALID && !prev_v) begin
                if (n == 0) chk("first_latency", cyc, k * k + 1);
                else chk("b2b_latency", cyc - hs, k * k + 1);
            end
            prev_v = AXIS_TVALID;
            AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            stall = AXIS_TVALID && !AXIS_TREADY;
            held = AXIS_TDATA;
            if (AXIS_TVALID && AXIS_TREADY) begin
                if (n == 0) chk("y0_hand", AXIS_TDATA, y0);
                chk("y_model", AXIS_TDATA, model(r, c, k, b));
                n++;
                hs = cyc + 1;
                c++;
                if (c > C - k) begin c = 0; r++; end
            end
        end
        if (cyc >= 3000) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d cycles required completion", cyc);
        end
        chk("output_count", n, nexp);
        chk("finished_pulses", cf, 1);
    endtask
    initial begin
        int n, cfc;
        v[0] = '{2, 0, 0, 0, 0, 0, 56, 4};
        v[1] = '{3, 5, 1, 1, 0, 0, 42, 14};
        v[2] = '{4, -1, 2, 2, 0, 0, 30, (64'sd1 << 50) - 1};
        v[3] = '{2, -3, 1, 0, 1, 0, 56, 15};
        v[4] = '{2, -3, 1, 0, 0, 0, 56, 15};
        v[5] = '{4, 2, 1, 0, 0, 1, 30, 218};
        v[6] = '{5, 0, 0, 0, 0, 0, 0, 0};
        v[7] = '{1, 0, 0, 0, 0, 0, 0, 0};
        v[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        fill(0, 0, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", AXIS_TVALID, 0);
        chk("rst_tdata", AXIS_TDATA, 0);
        chk("rst_finished", compute_finished, 0);
        chk("rst_xaddr", X_read_addr, 0);
        chk("rst_waddr", W_read_addr, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        foreach (v[t]) begin
            fill(v[t].xp, v[t].wp, v[t].k);
            K = K_BITS'(v[t].k);
            B = INW'(v[t].b);
            @(negedge clk);
            inputs_loaded = 1'b1;
            collect(v[t].k, v[t].b, v[t].n, v[t].y0, v[t].rnd, v[t].drop);
            inputs_loaded = 1'b0;
            repeat (3) @(posedge clk);
        end
        fill(0, 0, 2);
        K = 2;
        B = 0;
        @(negedge clk);
        inputs_loaded = 1'b1;
        AXIS_TREADY = 1'b1;
        n = 0;
        cfc = 0;
        for (int t = 0; t < 1000 && n < 9; t++) begin
            @(posedge clk);
            #1;
            if (compute_finished) cfc++;
            if (AXIS_TVALID) n++;
        end
        chk("abort_prefix_outputs", n, 9);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_tvalid", AXIS_TVALID, 0);
        chk("abort_tdata", AXIS_TDATA, 0);
        chk("abort_finished", compute_finished, 0);
        chk("abort_xaddr", X_read_addr, 0);
        chk("abort_waddr", W_read_addr, 0);
        chk("abort_prefix_pulses", cfc, 0);
        reset = 1'b0;
        K = 2;
        collect(2, 0, 56, 4, 0, 0);
        inputs_loaded = 1'b0;
        repeat (3) @(posedge clk);
        chk("xaddr_range_violations", xviol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
